// File: rtl/vx_avs_req_arbiter.sv
// vx_avs_req_arbiter: shares one AVS memory-wrapper request/response port among
// NUM_REQS requesters. Round-robin grant into a 1-entry registered request stage,
// requester index appended to the tag for response routing, and per-requester
// read credits that bound outstanding reads.
module vx_avs_req_arbiter #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned TAG_IN_WIDTH = 8,
    parameter int unsigned MAX_PENDING  = 16,
    localparam int unsigned SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS,
    localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    // requester side
    input  logic [NUM_REQS-1:0]              i_req_valid,
    input  logic [NUM_REQS-1:0]              i_req_rw,
    input  logic [NUM_REQS*BE_WIDTH-1:0]     i_req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] i_req_tag,
    output logic [NUM_REQS-1:0]              o_req_ready,
    output logic [NUM_REQS-1:0]              o_rsp_valid,
    output logic [DATA_WIDTH-1:0]            o_rsp_data,
    output logic [TAG_IN_WIDTH-1:0]          o_rsp_tag,
    input  logic [NUM_REQS-1:0]              i_rsp_ready,
    // memory wrapper side
    output logic                             o_mem_req_valid,
    output logic                             o_mem_req_rw,
    output logic [BE_WIDTH-1:0]              o_mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]            o_mem_req_addr,
    output logic [DATA_WIDTH-1:0]            o_mem_req_data,
    output logic [TAG_OUT_WIDTH-1:0]         o_mem_req_tag,
    input  logic                             i_mem_req_ready,
    input  logic                             i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            i_mem_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0]         i_mem_rsp_tag,
    output logic                             o_mem_rsp_ready,
    output logic                             o_busy
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_PENDING + 1);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // Registered request stage and arbitration state
    logic                     r_mem_req_valid;
    logic                     r_mem_req_rw;
    logic [BE_WIDTH-1:0]      r_mem_req_byteen;
    logic [ADDR_WIDTH-1:0]    r_mem_req_addr;
    logic [DATA_WIDTH-1:0]    r_mem_req_data;
    logic [TAG_OUT_WIDTH-1:0] r_mem_req_tag;
    logic [SEL_BITS-1:0]      r_ptr;
    cnt_t                     r_pend [NUM_REQS];

    // Combinational arbitration / routing signals
    logic [NUM_REQS-1:0]      w_elig;
    logic                     w_free;
    logic                     w_grant_any;
    logic                     w_grant;
    logic [SEL_BITS-1:0]      w_grant_idx;
    logic [SEL_BITS-1:0]      w_cand;
    logic                     w_sel_rw;
    logic [BE_WIDTH-1:0]      w_sel_byteen;
    logic [ADDR_WIDTH-1:0]    w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [TAG_IN_WIDTH-1:0]  w_sel_tag;
    logic [SEL_BITS-1:0]      w_rsp_idx;
    logic                     w_rsp_idx_ok;
    logic [NUM_REQS-1:0]      w_rsp_fire;
    logic [NUM_REQS-1:0]      w_pend_inc;
    logic [NUM_REQS-1:0]      w_pend_nz;

    // Eligibility: writes always eligible, reads only while credits remain
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            w_elig[i] = i_req_valid[i] & (i_req_rw[i] | (r_pend[i] < cnt_t'(MAX_PENDING)));
        end
    end

    // Stage can take a new request when empty or draining this cycle; no grants in reset
    assign w_free = i_reset_n & (~r_mem_req_valid | i_mem_req_ready);

    // Round-robin search: first eligible index strictly after the pointer, wrapping
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= int'(NUM_REQS); k++) begin
            w_cand = SEL_BITS'((int'(r_ptr) + k) % int'(NUM_REQS));
            if (!w_grant_any && w_elig[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_grant = w_free & w_grant_any;

    // Grant strobe back to the winning requester only
    always_comb begin
        o_req_ready = '0;
        if (w_grant) begin
            o_req_ready = NUM_REQS'(1) << w_grant_idx;
        end
    end

    // Payload mux for the winning requester
    always_comb begin
        w_sel_rw     = 1'b0;
        w_sel_byteen = '0;
        w_sel_addr   = '0;
        w_sel_data   = '0;
        w_sel_tag    = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (w_grant_idx == SEL_BITS'(i)) begin
                w_sel_rw     = i_req_rw[i];
                w_sel_byteen = i_req_byteen[i*BE_WIDTH +: BE_WIDTH];
                w_sel_addr   = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data   = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_tag    = i_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
            end
        end
    end

    // Output stage: load on grant, empty when free with no grant, hold while stalled
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mem_req_valid  <= 1'b0;
            r_mem_req_rw     <= 1'b0;
            r_mem_req_byteen <= '0;
            r_mem_req_addr   <= '0;
            r_mem_req_data   <= '0;
            r_mem_req_tag    <= '0;
            r_ptr            <= SEL_BITS'(NUM_REQS - 1);
        end else if (w_free) begin
            r_mem_req_valid <= w_grant;
            if (w_grant) begin
                r_mem_req_rw     <= w_sel_rw;
                r_mem_req_byteen <= w_sel_byteen;
                r_mem_req_addr   <= w_sel_addr;
                r_mem_req_data   <= w_sel_data;
                r_mem_req_tag    <= {w_sel_tag, w_grant_idx};
                r_ptr            <= w_grant_idx;
            end
        end
    end

    assign o_mem_req_valid  = r_mem_req_valid;
    assign o_mem_req_rw     = r_mem_req_rw;
    assign o_mem_req_byteen = r_mem_req_byteen;
    assign o_mem_req_addr   = r_mem_req_addr;
    assign o_mem_req_data   = r_mem_req_data;
    assign o_mem_req_tag    = r_mem_req_tag;

    // Response routing by the index carried in the low tag bits
    assign w_rsp_idx    = i_mem_rsp_tag[SEL_BITS-1:0];
    assign w_rsp_idx_ok = int'(w_rsp_idx) < int'(NUM_REQS);
    assign o_rsp_tag    = i_mem_rsp_tag[TAG_OUT_WIDTH-1:SEL_BITS];
    assign o_rsp_data   = i_mem_rsp_data;

    // Out-of-range index matches no requester: ready stays 1 so the response is dropped
    always_comb begin
        o_rsp_valid     = '0;
        o_mem_rsp_ready = 1'b1;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (w_rsp_idx == SEL_BITS'(i)) begin
                o_rsp_valid[i]  = i_mem_rsp_valid;
                o_mem_rsp_ready = i_rsp_ready[i];
            end
        end
    end

    // Per-requester credit events: read grant consumes, response handshake returns
    always_comb begin
        w_rsp_fire = '0;
        w_pend_inc = '0;
        w_pend_nz  = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            w_rsp_fire[i] = o_rsp_valid[i] & i_rsp_ready[i];
            w_pend_inc[i] = w_grant & (w_grant_idx == SEL_BITS'(i)) & ~i_req_rw[i];
            w_pend_nz[i]  = (r_pend[i] != '0);
        end
    end

    // Pending-read counters saturate at both ends; a stale response at 0 is ignored
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(NUM_REQS); i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REQS); i++) begin
                if (w_pend_inc[i] && !w_rsp_fire[i]) begin
                    if (r_pend[i] != cnt_t'(MAX_PENDING)) begin
                        r_pend[i] <= r_pend[i] + cnt_t'(1);
                    end
                end else if (!w_pend_inc[i] && w_rsp_fire[i]) begin
                    if (r_pend[i] != '0) begin
                        r_pend[i] <= r_pend[i] - cnt_t'(1);
                    end
                end
            end
        end
    end

    assign o_busy = r_mem_req_valid | (|w_pend_nz);

    // A response whose index names no requester indicates a wrapper or tag bug
    a_rsp_idx_in_range : assert property (
        @(posedge i_clk) disable iff (!i_reset_n) i_mem_rsp_valid |-> w_rsp_idx_ok
    );

endmodule

// File: tb/tb_vx_avs_req_arbiter.sv
// Self-checking bench for vx_avs_req_arbiter: per-feature tasks with inline checks,
// plus a scoreboard of expected memory requests popped as the DUT issues them.
module tb_vx_avs_req_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int MP  = 2;
    localparam int SB  = 2;
    localparam int TOW = TW + SB;
    localparam int BEW = DW / 8;

    typedef struct packed {
        logic           rw;
        logic [BEW-1:0] be;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [TOW-1:0] tag;
    } item_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_rw;
    logic [NR*BEW-1:0] req_byteen;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR*TW-1:0]  req_tag;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic [NR-1:0]     rsp_ready;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [BEW-1:0]    mem_req_byteen;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic [TOW-1:0]    mem_req_tag;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_data;
    logic [TOW-1:0]    mem_rsp_tag;
    logic              mem_rsp_ready;
    logic              busy;

    int    checks = 0;
    int    errors = 0;
    int    seq [NR];
    item_t sb [$];

    vx_avs_req_arbiter #(
        .NUM_REQS    (NR),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .TAG_IN_WIDTH(TW),
        .MAX_PENDING (MP)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_req_valid     (req_valid),
        .i_req_rw        (req_rw),
        .i_req_byteen    (req_byteen),
        .i_req_addr      (req_addr),
        .i_req_data      (req_data),
        .i_req_tag       (req_tag),
        .o_req_ready     (req_ready),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_data      (rsp_data),
        .o_rsp_tag       (rsp_tag),
        .i_rsp_ready     (rsp_ready),
        .o_mem_req_valid (mem_req_valid),
        .o_mem_req_rw    (mem_req_rw),
        .o_mem_req_byteen(mem_req_byteen),
        .o_mem_req_addr  (mem_req_addr),
        .o_mem_req_data  (mem_req_data),
        .o_mem_req_tag   (mem_req_tag),
        .i_mem_req_ready (mem_req_ready),
        .i_mem_rsp_valid (mem_rsp_valid),
        .i_mem_rsp_data  (mem_rsp_data),
        .i_mem_rsp_tag   (mem_rsp_tag),
        .o_mem_rsp_ready (mem_rsp_ready),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Payload of requester i depends on its running sequence number
    task automatic drive_payload();
        for (int i = 0; i < NR; i++) begin
            req_byteen[i*BEW +: BEW] = BEW'(seq[i] + i + 1);
            req_addr[i*AW +: AW]     = AW'(i * 4096 + seq[i]);
            req_data[i*DW +: DW]     = DW'(32'hD000_0000 + i * 256 + seq[i]);
            req_tag[i*TW +: TW]      = TW'(i * 16 + seq[i] + 1);
        end
    endtask

    function automatic item_t exp_item(input int g);
        item_t it;
        it.rw   = req_rw[g];
        it.be   = BEW'(seq[g] + g + 1);
        it.addr = AW'(g * 4096 + seq[g]);
        it.data = DW'(32'hD000_0000 + g * 256 + seq[g]);
        it.tag  = {TW'(g * 16 + seq[g] + 1), SB'(g)};
        return it;
    endfunction

    // Scoreboard: one request out per cycle behind each grant, in grant order
    always @(negedge clk) begin
        item_t e;
        if (mem_req_ready === 1'b1) begin
            checks++;
            if (mem_req_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL occupancy: mem_req_valid=%b expected %b", mem_req_valid,
                         sb.size() != 0);
            end
            if (mem_req_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag} !== e)
                begin
                    errors++;
                    $display("FAIL mem_req: got rw=%b be=%h addr=%h data=%h tag=%h expected %h",
                             mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
                             e);
                end
            end
        end
    end

    // One cycle: check grant vector g (-1 = none) and queue the expected request
    task automatic cycle_expect(input int g);
        logic [NR-1:0] exp;
        item_t         it;
        @(negedge clk);
        exp = (g >= 0) ? (NR'(1) << g) : '0;
        checks++;
        if (req_ready !== exp) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp);
        end
        if (g >= 0) it = exp_item(g);
        @(posedge clk);
        #1;
        if (g >= 0) begin
            sb.push_back(it);
            seq[g]++;
            drive_payload();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d requests never issued, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n       = 1'b0;
        req_valid     = '0;
        req_rw        = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_tag   = '0;
        mem_rsp_data  = '0;
        rsp_ready     = '1;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        drive_payload();
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: busy=%b mem_req_valid=%b expected 0 0", busy,
                     mem_req_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        req_valid     = '1;
        req_rw        = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_tag   = '0;
        mem_rsp_data  = '0;
        rsp_ready     = '1;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        drive_payload();
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: mem_req_valid=%b expected 0", mem_req_valid);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b expected 0000", req_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle_expect(0);
        req_valid = '0;
        drain();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_pending: busy=%b expected 1", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr();
        do_reset();
        req_rw    = '0;
        req_valid = '1;
        for (int k = 0; k < 8; k++) cycle_expect(k % NR);
        // Every requester now holds MAX_PENDING reads
        cycle_expect(-1);
        req_valid = '0;
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_rw    = '1;
        req_valid = '1;
        for (int k = 0; k < 12; k++) cycle_expect(k % NR);
        req_valid = '0;
        drain();
    endtask

    task automatic test_backpressure();
        item_t held;
        do_reset();
        mem_req_ready = 1'b0;
        req_rw        = 4'b0100;
        req_valid     = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_first: req_ready=%b expected 0100", req_ready);
        end
        held = exp_item(2);
        @(posedge clk);
        #1;
        sb.push_back(held);
        seq[2]++;
        drive_payload();
        req_valid = 4'b0101;
        req_rw    = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready: req_ready=%b expected 0000", req_ready);
            end
            checks++;
            if (mem_req_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_valid: mem_req_valid=%b expected 1", mem_req_valid);
            end
            checks++;
            if ({mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag} !== held)
            begin
                errors++;
                $display("FAIL bp_hold: got tag=%h addr=%h expected %h", mem_req_tag,
                         mem_req_addr, held);
            end
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b1;
        cycle_expect(0);
        req_valid = '0;
        drain();
    endtask

    task automatic test_credits();
        do_reset();
        req_rw    = '0;
        req_valid = 4'b0010;
        cycle_expect(1);
        cycle_expect(1);
        cycle_expect(-1);
        req_rw = 4'b0010;
        cycle_expect(1);
        req_rw = '0;
        cycle_expect(-1);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h33, 2'd1};
        mem_rsp_data  = 32'h1234_5678;
        rsp_ready     = 4'b0010;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0010 || mem_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_rsp: rsp_valid=%b mem_rsp_ready=%b expected 0010 1",
                     rsp_valid, mem_rsp_ready);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL credit_same_cycle: req_ready=%b expected 0000", req_ready);
        end
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        rsp_ready     = '1;
        cycle_expect(1);
        cycle_expect(-1);
        req_valid = '0;
        drain();
    endtask

    task automatic test_routing();
        do_reset();
        req_rw    = '0;
        req_valid = 4'b0100;
        cycle_expect(2);
        cycle_expect(2);
        cycle_expect(-1);
        req_valid = '0;
        drain();
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'hA5, 2'd2};
        mem_rsp_data  = 32'hCAFE_F00D;
        rsp_ready     = 4'b1011;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0100) begin
            errors++;
            $display("FAIL route_valid: rsp_valid=%b expected 0100", rsp_valid);
        end
        checks++;
        if (rsp_tag !== 8'hA5) begin
            errors++;
            $display("FAIL route_tag: rsp_tag=%h expected a5", rsp_tag);
        end
        checks++;
        if (rsp_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL route_data: rsp_data=%h expected cafef00d", rsp_data);
        end
        checks++;
        if (mem_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL route_notready: mem_rsp_ready=%b expected 0", mem_rsp_ready);
        end
        @(posedge clk);
        #1;
        rsp_ready = '1;
        @(negedge clk);
        checks++;
        if (mem_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL route_ready: mem_rsp_ready=%b expected 1", mem_rsp_ready);
        end
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        // Exactly one credit came back to requester 2
        req_valid = 4'b0100;
        cycle_expect(2);
        cycle_expect(-1);
        req_valid = '0;
        drain();
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h5A, 2'd0};
        mem_rsp_data  = 32'h0BAD_0000;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || mem_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL stale_rsp: rsp_valid=%b mem_rsp_ready=%b expected 0001 1",
                     rsp_valid, mem_rsp_ready);
        end
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_busy: busy=%b expected 0", busy);
        end
        @(posedge clk);
        #1;
        // Counter 0 must still be 0: exactly MAX_PENDING reads go through
        req_rw    = '0;
        req_valid = 4'b0001;
        cycle_expect(0);
        cycle_expect(0);
        cycle_expect(-1);
        req_valid = 4'b1000;
        cycle_expect(3);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h77, 2'd3};
        cycle_expect(3);
        mem_rsp_valid = 1'b0;
        cycle_expect(3);
        cycle_expect(-1);
        req_valid = '0;
        drain();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mem_req_ready = 1'b0;
        req_rw        = 4'b0001;
        req_valid     = 4'b0001;
        cycle_expect(0);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_held: mem_req_valid=%b expected 1", mem_req_valid);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_drop: mem_req_valid=%b expected 0", mem_req_valid);
        end
        sb.delete();
        do_reset();
    endtask

    initial begin
        test_reset();
        test_rr();
        test_back_to_back();
        test_backpressure();
        test_credits();
        test_routing();
        test_simultaneous();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
